// File: rtl/resource_arbiter_if.sv
`default_nettype none
// ============================================================================
// resource_arbiter_if
//   Request/grant/data bundle between the pipeline requesters and the arbiter.
//   Revision: 1.0
// ============================================================================
interface resource_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      flush;
  logic [NUM_REQ-1:0]        grant;
  logic                      grant_valid;
  logic [c_id_w-1:0]         grant_id;
  logic [DATA_W-1:0]         resource_data;
  logic                      resource_valid;

  modport master (
    output req, req_data, flush,
    input  grant, grant_valid, grant_id, resource_data, resource_valid
  );

  modport slave (
    input  req, req_data, flush,
    output grant, grant_valid, grant_id, resource_data, resource_valid
  );
endinterface
`default_nettype wire

// File: rtl/resource_arbiter.sv
`default_nettype none
// ============================================================================
// resource_arbiter
//   Round-robin arbiter with bounded tenure and owner data steering.
//   Revision: 1.0
// ============================================================================
module resource_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  resource_arbiter_if.slave  arb
);
  localparam int            c_id_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]    c_max_hold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [c_id_w-1:0]    r_grant_id;
  logic [c_id_w-1:0]    r_last_id;
  logic [7:0]           r_hold_cnt;

  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [c_id_w-1:0]    w_grant_id_nxt;
  logic [c_id_w-1:0]    w_last_id_nxt;
  logic [7:0]           w_hold_cnt_nxt;

  logic [NUM_REQ-1:0]   w_scan_req;
  logic [2*NUM_REQ-1:0] w_scan_dbl;
  logic [c_id_w:0]      w_shamt;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_pick_found;
  logic [c_id_w-1:0]    w_pick_id;
  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic                 w_owner_req;
  logic [7:0]           w_hold_inc;
  logic [DATA_W-1:0]    w_res_data;

  // While owned, the owner is masked out so a pick is always a different requester.
  assign w_scan_req    = (r_state == S_OWNED) ? (arb.req & ~r_grant) : arb.req;
  assign w_scan_dbl    = {w_scan_req, w_scan_req};
  assign w_shamt       = {1'b0, r_last_id} + (c_id_w+1)'(1);
  assign w_rot         = NUM_REQ'(w_scan_dbl >> w_shamt);
  assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_id;
  assign w_owner_req   = |(arb.req & r_grant);
  assign w_hold_inc    = (r_hold_cnt >= c_max_hold) ? c_max_hold : r_hold_cnt + 8'd1;

  // w_rot bit k corresponds to requester (last_id + 1 + k) mod NUM_REQ.
  always_comb begin
    int v_off;
    int v_sum;
    w_pick_found = 1'b0;
    v_off        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pick_found = 1'b1;
        v_off        = k;
      end
    end
    v_sum = int'(r_last_id) + 1 + v_off;
    if (v_sum >= NUM_REQ) begin
      v_sum = v_sum - NUM_REQ;
    end
    w_pick_id = c_id_w'(v_sum);
  end

  always_comb begin
    logic v_take;
    logic v_drop;
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_last_id_nxt  = r_last_id;
    w_hold_cnt_nxt = r_hold_cnt;
    v_take         = 1'b0;
    v_drop         = 1'b0;

    case (r_state)
      S_OWNED: begin
        if (arb.flush) begin
          v_drop = 1'b1;
        end else if (!w_owner_req) begin
          v_take = w_pick_found;
          v_drop = !w_pick_found;
        end else if ((r_hold_cnt >= c_max_hold) && w_pick_found) begin
          v_take = 1'b1;
        end else begin
          w_hold_cnt_nxt = w_hold_inc;
        end
      end
      default: begin
        v_take = w_pick_found;
      end
    endcase

    if (v_take) begin
      w_state_nxt    = S_OWNED;
      w_grant_nxt    = w_pick_onehot;
      w_grant_id_nxt = w_pick_id;
      w_last_id_nxt  = w_pick_id;
      w_hold_cnt_nxt = 8'd1;
    end else if (v_drop) begin
      w_state_nxt    = S_IDLE;
      w_grant_nxt    = '0;
      w_grant_id_nxt = '0;
      w_hold_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_last_id  <= c_id_w'(NUM_REQ - 1);
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_last_id  <= w_last_id_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // One-hot grant steers the owner's slice; all-zero grant yields zero data.
  always_comb begin
    w_res_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_res_data = arb.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign arb.grant          = r_grant;
  assign arb.grant_valid    = |r_grant;
  assign arb.grant_id       = r_grant_id;
  assign arb.resource_data  = w_res_data;
  assign arb.resource_valid = |(r_grant & arb.req);

endmodule
`default_nettype wire
